i2s_rx_master: RTL

// - I2S master receiver for the stereo ADC. Generates bclk/lrclk from clk, deserialises sdin, and presents

---
 rtl/audio_pkg.sv | 14 +
 rtl/i2s_clk_gen.sv | 64 ++++++
 rtl/i2s_rx_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio types for the I2S front end, filter bank and DAC transmitter.
`timescale 1ns/1ps
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit/word clock generator for the I2S master: divides clk into bclk, counts
// bclk periods per frame and derives lrclk plus the slot-relative bit position.
`timescale 1ns/1ps
module i2s_clk_gen #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_run,
  output logic                        o_bclk,
  output logic                        o_lrclk,
  output logic                        o_rise_evt,
  output logic [$clog2(SLOT_W)-1:0]   o_pos
);

  localparam int DIV_W = $clog2(BCLK_HALF);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int POS_W = $clog2(SLOT_W);

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_BITS = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_next;
  logic             r_bclk;
  logic             r_lrclk;
  logic             w_wrap;
  logic             w_rise_evt;
  logic             w_fall_evt;

  assign w_wrap     = i_run && (r_div_cnt == DIV_MAX);
  assign w_rise_evt = w_wrap && !r_bclk;
  assign w_fall_evt = w_wrap &&  r_bclk;
  assign w_bit_next = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + BIT_W'(1);

  // Stopping the interface returns both clocks low and rewinds to the left slot,
  // so the next start always begins a fresh frame.
  always_ff @(posedge clk) begin
    if (reset || !i_run) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
      if (w_fall_evt) begin
        r_bit_cnt <= w_bit_next;
        r_lrclk   <= (w_bit_next >= SLOT_BITS);
      end
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign o_bclk     = r_bclk;
  assign o_lrclk    = r_lrclk;
  assign o_rise_evt = w_rise_evt;
  assign o_pos      = POS_W'(r_lrclk ? (r_bit_cnt - SLOT_BITS) : r_bit_cnt);

endmodule

// File: rtl/i2s_rx_master.sv
// I2S master receiver: drives bclk/lrclk, deserialises sdin and presents a
// left/right signed sample pair with a single-cycle sample_valid strobe per frame.
`timescale 1ns/1ps
module i2s_rx_master #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_W    = 32,
  parameter int SAMPLE_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sdin,
  output logic                       bclk,
  output logic                       lrclk,
  output logic signed [SAMPLE_W-1:0] sample_l,
  output logic signed [SAMPLE_W-1:0] sample_r,
  output logic                       sample_valid
);

  import audio_pkg::*;

  localparam int POS_W = $clog2(SLOT_W);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(SAMPLE_W);

  i2s_state_t r_state;
  i2s_state_t w_state_next;
  logic       w_run;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rise;
  logic [POS_W-1:0] w_pos;
  logic             w_capture;
  logic             w_last_bit;

  logic signed [SAMPLE_W-1:0] r_shift;
  logic signed [SAMPLE_W-1:0] w_shift_next;
  logic signed [SAMPLE_W-1:0] r_hold;
  logic signed [SAMPLE_W-1:0] r_sample_l;
  logic signed [SAMPLE_W-1:0] r_sample_r;
  logic                       r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // w_run drops in the same cycle enable falls, so the clock generator clears
  // on the very next edge rather than finishing the current bclk half-period.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (enable) begin
          w_run = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  i2s_clk_gen #(
    .BCLK_HALF (BCLK_HALF),
    .SLOT_W    (SLOT_W)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_run),
    .o_bclk     (bclk),
    .o_lrclk    (lrclk),
    .o_rise_evt (w_rise),
    .o_pos      (w_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sdin;
      r_sync2 <= r_sync1;
    end
  end

  // Position 0 is the one-bclk I2S delay slot; anything past SAMPLE_W is
  // extra ADC resolution that is dropped (truncation, no rounding).
  assign w_capture    = w_rise && (w_pos != '0) && (w_pos <= LAST_POS);
  assign w_last_bit   = w_capture && (w_pos == LAST_POS);
  assign w_shift_next = {r_shift[SAMPLE_W-2:0], r_sync2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_hold     <= '0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!w_run) begin
        r_shift <= '0;
        r_hold  <= '0;
      end else if (w_capture) begin
        r_shift <= w_shift_next;
        if (w_last_bit && !lrclk) begin
          r_hold <= w_shift_next;
        end
        // Both channels publish together at the end of the right word.
        if (w_last_bit && lrclk) begin
          r_sample_l <= r_hold;
          r_sample_r <= w_shift_next;
          r_valid    <= 1'b1;
        end
      end
    end
  end

  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign sample_valid = r_valid;

endmodule
